// File: rtl/register_file_mp.sv
// register_file_mp: parameterised register file with two write ports, two
// registered read ports and a per-register busy scoreboard.
//
// Optional feature macro: SCOREBOARD_BYPASS_EN
//   defined   -> write-first reads. A/B and busy_A/busy_B capture the
//                post-update state of the same edge.
//   undefined -> read-before-write. A/B and busy_A/busy_B capture the state
//                from before the edge's writes and issue.
module register_file_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NREG     = 32,
   parameter int ZERO_REG = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   input  logic [ADDR_W-1:0] rs1,
   input  logic [ADDR_W-1:0] rs2,
   input  logic              we0,
   input  logic [ADDR_W-1:0] rd0,
   input  logic [DATA_W-1:0] Din0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] rd1,
   input  logic [DATA_W-1:0] Din1,
   input  logic              issue_en,
   input  logic [ADDR_W-1:0] issue_rd,
   output logic [DATA_W-1:0] A,
   output logic [DATA_W-1:0] B,
   output logic              busy_A,
   output logic              busy_B,
   output logic              stall
);

   // Register count widened by one bit so it can hold 2**ADDR_W.
   localparam logic [ADDR_W:0] NREG_L = (ADDR_W+1)'(NREG);

   logic [DATA_W-1:0] regs     [NREG];
   logic [DATA_W-1:0] regs_nxt [NREG];
   logic [NREG-1:0]   busy;
   logic [NREG-1:0]   busy_nxt;
   logic [DATA_W-1:0] a_val;
   logic [DATA_W-1:0] b_val;
   logic              a_busy;
   logic              b_busy;

   // An address names a real, writable register: in range and not the
   // hardwired zero register. Writes, issues and reads share this rule.
   function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
      return ({1'b0, a} < NREG_L) && !((ZERO_REG != 0) && (a == '0));
   endfunction

   // Next array and scoreboard state; port 1 overrides port 0, issue overrides writes.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      regs_nxt = regs;
      busy_nxt = busy;
      if (we0 && addr_ok(rd0)) begin
         regs_nxt[rd0] = Din0;
         busy_nxt[rd0] = 1'b0;
      end
      if (we1 && addr_ok(rd1)) begin
         regs_nxt[rd1] = Din1;
         busy_nxt[rd1] = 1'b0;
      end
      if (issue_en && addr_ok(issue_rd)) begin
         busy_nxt[issue_rd] = 1'b1;
      end
   end

   // Read-port selection; unmapped and zero-register addresses read as 0, not busy.
   always_comb begin
      a_val  = '0;
      b_val  = '0;
      a_busy = 1'b0;
      b_busy = 1'b0;
`ifdef SCOREBOARD_BYPASS_EN
      if (addr_ok(rs1)) begin
         a_val  = regs_nxt[rs1];
         a_busy = busy_nxt[rs1];
      end
      if (addr_ok(rs2)) begin
         b_val  = regs_nxt[rs2];
         b_busy = busy_nxt[rs2];
      end
`else
      if (addr_ok(rs1)) begin
         a_val  = regs[rs1];
         a_busy = busy[rs1];
      end
      if (addr_ok(rs2)) begin
         b_val  = regs[rs2];
         b_busy = busy[rs2];
      end
`endif
   end

   // State and read-port registers: synchronous reset, then freeze when disabled.
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (reset) begin
         // NOTE: the array is reset explicitly because reset must clear every
         // register; this keeps it in flops rather than a RAM macro.
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
         busy   <= '0;
         A      <= '0;
         B      <= '0;
         busy_A <= 1'b0;
         busy_B <= 1'b0;
      end else if (enable) begin
         regs   <= regs_nxt;
         busy   <= busy_nxt;
         A      <= a_val;
         B      <= b_val;
         busy_A <= a_busy;
         busy_B <= b_busy;
      end
   end

   assign stall = busy_A | busy_B;

endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: table-driven directed test for register_file_mp with
// default parameters (32 x 32-bit, ZERO_REG=1). Expected values follow the
// build's read mode (SCOREBOARD_BYPASS_EN defined or not).
module tb_register_file_mp;

`ifdef SCOREBOARD_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset, enable, we0, we1, issue_en;
   logic [4:0]  rs1, rs2, rd0, rd1, issue_rd;
   logic [31:0] Din0, Din1;
   logic [31:0] A, B;
   logic        busy_A, busy_B, stall;

   int total = 0;
   int bad   = 0;

   register_file_mp dut (
      .clock(clock), .reset(reset), .enable(enable),
      .rs1(rs1), .rs2(rs2),
      .we0(we0), .rd0(rd0), .Din0(Din0),
      .we1(we1), .rd1(rd1), .Din1(Din1),
      .issue_en(issue_en), .issue_rd(issue_rd),
      .A(A), .B(B), .busy_A(busy_A), .busy_B(busy_B), .stall(stall)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        reset, enable;
      logic [4:0]  rs1, rs2;
      logic        we0;
      logic [4:0]  rd0;
      logic [31:0] din0;
      logic        we1;
      logic [4:0]  rd1;
      logic [31:0] din1;
      logic        issue_en;
      logic [4:0]  issue_rd;
      logic [31:0] ea, eb;
      logic        eba, ebb;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Read-only vector with the given expected outputs; callers add writes/issues.
   function automatic vec_t rdv(input logic [4:0] a1, input logic [4:0] a2,
                                input logic [31:0] ea, input logic [31:0] eb,
                                input logic eba, input logic ebb);
      vec_t v;
      v.reset = 1'b0;  v.enable = 1'b1;
      v.rs1 = a1;      v.rs2 = a2;
      v.we0 = 1'b0;    v.rd0 = '0;  v.din0 = '0;
      v.we1 = 1'b0;    v.rd1 = '0;  v.din1 = '0;
      v.issue_en = 1'b0; v.issue_rd = '0;
      v.ea = ea; v.eb = eb; v.eba = eba; v.ebb = ebb;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      reset = v.reset; enable = v.enable; rs1 = v.rs1; rs2 = v.rs2;
      we0 = v.we0; rd0 = v.rd0; Din0 = v.din0;
      we1 = v.we1; rd1 = v.rd1; Din1 = v.din1;
      issue_en = v.issue_en; issue_rd = v.issue_rd;
   endtask

   task automatic check_outs(input string tag, input logic [31:0] ea, input logic [31:0] eb,
                             input logic eba, input logic ebb);
      check({tag, ".A"}, A, ea);
      check({tag, ".B"}, B, eb);
      check({tag, ".busy_A"}, {31'b0, busy_A}, {31'b0, eba});
      check({tag, ".busy_B"}, {31'b0, busy_B}, {31'b0, ebb});
      check({tag, ".stall"}, {31'b0, stall}, {31'b0, eba | ebb});
   endtask

   initial begin
      vec_t v;

      // Reset held two cycles, then a plain read.
      v = rdv(5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0); v.reset = 1'b1; tbl.push_back(v);
      tbl.push_back(v);
      tbl.push_back(rdv(5'd1, 5'd2, 32'h0, 32'h0, 1'b0, 1'b0));
      // Write reg3 while reading it, then read it back.
      v = rdv(5'd3, 5'd4, BYP ? 32'h12345678 : 32'h0, 32'h0, 1'b0, 1'b0);
      v.we0 = 1'b1; v.rd0 = 5'd3; v.din0 = 32'h12345678; tbl.push_back(v);
      tbl.push_back(rdv(5'd3, 5'd4, 32'h12345678, 32'h0, 1'b0, 1'b0));
      // Dual write to reg10: port 1 wins.
      v = rdv(5'd10, 5'd0, BYP ? 32'h69420632 : 32'h0, 32'h0, 1'b0, 1'b0);
      v.we0 = 1'b1; v.rd0 = 5'd10; v.din0 = 32'h15328054;
      v.we1 = 1'b1; v.rd1 = 5'd10; v.din1 = 32'h69420632; tbl.push_back(v);
      tbl.push_back(rdv(5'd10, 5'd0, 32'h69420632, 32'h0, 1'b0, 1'b0));
      // Write to reg0 ignored; same-cycle write to reg17 read on port A.
      v = rdv(5'd17, 5'd0, BYP ? 32'h00100234 : 32'h0, 32'h0, 1'b0, 1'b0);
      v.we0 = 1'b1; v.rd0 = 5'd0;  v.din0 = 32'hA5A5A5A5;
      v.we1 = 1'b1; v.rd1 = 5'd17; v.din1 = 32'h00100234; tbl.push_back(v);
      tbl.push_back(rdv(5'd0, 5'd17, 32'h0, 32'h00100234, 1'b0, 1'b0));
      // Issue reg24, observe busy, then complete it on port 1.
      v = rdv(5'd24, 5'd0, 32'h0, 32'h0, BYP, 1'b0);
      v.issue_en = 1'b1; v.issue_rd = 5'd24; tbl.push_back(v);
      tbl.push_back(rdv(5'd24, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0));
      v = rdv(5'd24, 5'd0, BYP ? 32'h53601518 : 32'h0, 32'h0, !BYP, 1'b0);
      v.we1 = 1'b1; v.rd1 = 5'd24; v.din1 = 32'h53601518; tbl.push_back(v);
      tbl.push_back(rdv(5'd24, 5'd0, 32'h53601518, 32'h0, 1'b0, 1'b0));
      // Issue and write to reg30 on the same edge: issue wins.
      v = rdv(5'd30, 5'd30, BYP ? 32'h11111111 : 32'h0, BYP ? 32'h11111111 : 32'h0, BYP, BYP);
      v.issue_en = 1'b1; v.issue_rd = 5'd30;
      v.we0 = 1'b1; v.rd0 = 5'd30; v.din0 = 32'h11111111; tbl.push_back(v);
      tbl.push_back(rdv(5'd30, 5'd24, 32'h11111111, 32'h53601518, 1'b1, 1'b0));
      // enable=0 during a write to reg31: outputs hold, reg31 untouched.
      v = rdv(5'd31, 5'd3, 32'h11111111, 32'h53601518, 1'b1, 1'b0);
      v.enable = 1'b0; v.we0 = 1'b1; v.rd0 = 5'd31; v.din0 = 32'hDEADBEEF; tbl.push_back(v);
      tbl.push_back(rdv(5'd31, 5'd3, 32'h0, 32'h12345678, 1'b0, 1'b0));
      // Issue to reg0 is ignored.
      v = rdv(5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
      v.issue_en = 1'b1; v.issue_rd = 5'd0; tbl.push_back(v);
      tbl.push_back(rdv(5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0));
      // Reserve reg24 again with a write to reg5 in flight, then reset.
      v = rdv(5'd24, 5'd0, 32'h53601518, 32'h0, BYP, 1'b0);
      v.issue_en = 1'b1; v.issue_rd = 5'd24;
      v.we0 = 1'b1; v.rd0 = 5'd5; v.din0 = 32'h55555555; tbl.push_back(v);
      v = rdv(5'd24, 5'd5, 32'h0, 32'h0, 1'b0, 1'b0);
      v.reset = 1'b1; v.we1 = 1'b1; v.rd1 = 5'd6; v.din1 = 32'h66666666;
      v.issue_en = 1'b1; v.issue_rd = 5'd7; tbl.push_back(v);
      tbl.push_back(rdv(5'd24, 5'd5, 32'h0, 32'h0, 1'b0, 1'b0));
      tbl.push_back(rdv(5'd6, 5'd7, 32'h0, 32'h0, 1'b0, 1'b0));

      foreach (tbl[i]) begin
         drive(tbl[i]);
         @(posedge clock);
         #1;
         check_outs($sformatf("vec%0d", i), tbl[i].ea, tbl[i].eb, tbl[i].eba, tbl[i].ebb);
      end

      // Hand sequence: reg9 written, then a multi-cycle freeze with an issue
      // pending on its input must neither change outputs nor set busy[9].
      v = rdv(5'd9, 5'd9, 32'h0, 32'h0, 1'b0, 1'b0);
      v.we0 = 1'b1; v.rd0 = 5'd9; v.din0 = 32'h00000099;
      drive(v);
      @(posedge clock); #1;
      drive(rdv(5'd9, 5'd9, 32'h0, 32'h0, 1'b0, 1'b0));
      @(posedge clock); #1;
      check_outs("seq_rd9", 32'h99, 32'h99, 1'b0, 1'b0);
      v = rdv(5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
      v.enable = 1'b0; v.issue_en = 1'b1; v.issue_rd = 5'd9;
      drive(v);
      for (int c = 0; c < 3; c++) begin
         @(posedge clock); #1;
         check_outs($sformatf("seq_hold%0d", c), 32'h99, 32'h99, 1'b0, 1'b0);
      end
      drive(rdv(5'd9, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0));
      @(posedge clock); #1;
      check_outs("seq_after", 32'h99, 32'h0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
